// File: rtl/input_port_bank.sv
// Memory-mapped bank of synchronised input ports with sticky change flags.
// Optional registered interrupt request when INPUT_PORT_IRQ_EN is defined.
module input_port_bank #(
  parameter int                NUM_PORTS   = 16,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] PORT_BASE   = 8'hF0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        read,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  output logic [NUM_PORTS-1:0]        change_flags,
  input  logic [NUM_PORTS-1:0]        irq_mask,
  output logic                        irq
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam int LAST   = SYNC_STAGES - 1;
  localparam logic [ADDR_W:0] BASE = {1'b0, PORT_BASE};
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_PORTS);

  logic [NUM_PORTS*DATA_W-1:0] sync_r [SYNC_STAGES];
  logic [NUM_PORTS*DATA_W-1:0] prev;
  logic [WARM_W-1:0]           warm;
  logic                        live;
  logic [ADDR_W:0]             off;
  logic [IDX_W-1:0]            idx;
  logic                        hit;
  logic [DATA_W-1:0]           sel;
  logic [NUM_PORTS-1:0]        diff;
  logic [NUM_PORTS-1:0]        clr;
  logic [NUM_PORTS-1:0]        flags_n;

  // Extra guard bit: an address below the base shows up as a borrow.
  assign off = {1'b0, address} - BASE;
  assign hit = read && !off[ADDR_W] && (off < SPAN);
  assign idx = off[IDX_W-1:0];

  always_comb begin
    sel  = '0;
    diff = '0;
    clr  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      diff[i] = sync_r[LAST][i*DATA_W +: DATA_W]
             != prev[i*DATA_W +: DATA_W];
      if (hit && idx == IDX_W'(i)) begin
        clr[i] = 1'b1;
        sel    = sync_r[LAST][i*DATA_W +: DATA_W];
      end
    end
    flags_n = (live ? diff : '0) | (change_flags & ~clr);
  end

  // live trails the counter by one edge so prev has caught up with
  // the first synchronised sample before detection is armed.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
      prev         <= '0;
      warm         <= WARM_W'(SYNC_STAGES);
      live         <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      change_flags <= '0;
    end else begin
      sync_r[0] <= port_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      prev <= sync_r[LAST];
      if (warm != '0) warm <= warm - WARM_W'(1);
      live         <= (warm == '0);
      data_valid   <= hit;
      if (hit) data_out <= sel;
      change_flags <= flags_n;
    end
  end

`ifdef INPUT_PORT_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(change_flags & irq_mask);
  end
`else
  logic unused_mask;
  assign unused_mask = ^irq_mask;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_bank.sv
// Directed bench for input_port_bank at default parameters.
// Expected irq behaviour follows INPUT_PORT_IRQ_EN.
module tb_input_port_bank;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] port_in;
  logic [7:0]   address;
  logic         read;
  logic [7:0]   data_out;
  logic         data_valid;
  logic [15:0]  change_flags;
  logic [15:0]  irq_mask;
  logic         irq;

  logic [7:0]   ports [16];
  int total = 0;
  int bad   = 0;

`ifdef INPUT_PORT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  input_port_bank dut (
    .clock(clock), .reset(reset), .port_in(port_in),
    .address(address), .read(read), .data_out(data_out),
    .data_valid(data_valid), .change_flags(change_flags),
    .irq_mask(irq_mask), .irq(irq)
  );

  always #5 clock = ~clock;

  always_comb
    for (int i = 0; i < 16; i++) port_in[i*8 +: 8] = ports[i];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a);
    read    = 1'b1;
    address = a;
    tick();
    read    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    read     = 1'b0;
    address  = 8'h00;
    irq_mask = 16'h0000;
    for (int i = 0; i < 16; i++) ports[i] = 8'hAA;
    repeat (3) tick();
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_flags", 32'(change_flags), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("warm_flags", 32'(change_flags), 32'h0);
    end

    // two ports change; flags rise exactly two edges later
    ports[0]  = 8'hCC;
    ports[15] = 8'hFF;
    tick();
    chk("lat_e0", 32'(change_flags), 32'h0);
    tick();
    chk("lat_e1", 32'(change_flags), 32'h0);
    tick();
    chk("lat_e2", 32'(change_flags), 32'h8001);

    read = 1'b1;
    address = 8'hF0;
    tick();
    chk("rd_f0_data", 32'(data_out), 32'hCC);
    chk("rd_f0_valid", 32'(data_valid), 32'h1);
    chk("rd_f0_flags", 32'(change_flags), 32'h8000);
    address = 8'hFF;
    tick();
    chk("rd_ff_data", 32'(data_out), 32'hFF);
    chk("rd_ff_valid", 32'(data_valid), 32'h1);
    chk("rd_ff_flags", 32'(change_flags), 32'h0000);
    read = 1'b0;
    tick();
    chk("idle_valid", 32'(data_valid), 32'h0);
    chk("idle_data", 32'(data_out), 32'hFF);

    // misses must leave data and flags alone
    ports[5] = 8'h55;
    repeat (3) tick();
    chk("p5_flag", 32'(change_flags), 32'h0020);
    rd(8'h10);
    chk("miss10_valid", 32'(data_valid), 32'h0);
    chk("miss10_data", 32'(data_out), 32'hFF);
    chk("miss10_flags", 32'(change_flags), 32'h0020);
    rd(8'hEF);
    chk("missEF_valid", 32'(data_valid), 32'h0);
    chk("missEF_data", 32'(data_out), 32'hFF);
    chk("missEF_flags", 32'(change_flags), 32'h0020);
    rd(8'hF5);
    chk("rd_f5_data", 32'(data_out), 32'h55);
    chk("rd_f5_flags", 32'(change_flags), 32'h0000);

    // port3 33 -> 34
    ports[3] = 8'h33;
    repeat (3) tick();
    rd(8'hF3);
    chk("p3_33_data", 32'(data_out), 32'h33);
    chk("p3_33_flags", 32'(change_flags), 32'h0000);
    ports[3] = 8'h34;
    tick();
    chk("p3_e0", 32'(change_flags), 32'h0000);
    tick();
    chk("p3_e1", 32'(change_flags), 32'h0000);
    tick();
    chk("p3_e2", 32'(change_flags), 32'h0008);
    rd(8'hF3);
    chk("p3_34_data", 32'(data_out), 32'h34);
    chk("p3_34_flags", 32'(change_flags), 32'h0000);

    // set and clear on the same edge: set wins
    ports[3] = 8'h35;
    tick();
    tick();
    rd(8'hF3);
    chk("coll_data", 32'(data_out), 32'h35);
    chk("coll_flags", 32'(change_flags), 32'h0008);
    rd(8'hF3);
    chk("coll_clr", 32'(change_flags), 32'h0000);

    // unmasked change
    irq_mask = 16'h0008;
    ports[3] = 8'h36;
    repeat (3) tick();
    chk("irq_flag", 32'(change_flags), 32'h0008);
    chk("irq_lag", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'(IRQ_ON));
    rd(8'hF3);
    chk("irq_clr_flag", 32'(change_flags), 32'h0000);
    chk("irq_hold", 32'(irq), 32'(IRQ_ON));
    tick();
    chk("irq_drop", 32'(irq), 32'h0);

    // masked change
    irq_mask = 16'h0000;
    ports[3] = 8'h37;
    repeat (3) tick();
    chk("mask_flag", 32'(change_flags), 32'h0008);
    tick();
    chk("mask_irq0", 32'(irq), 32'h0);
    tick();
    chk("mask_irq1", 32'(irq), 32'h0);
    rd(8'hF3);
    chk("mask_clr", 32'(change_flags), 32'h0000);

    // reset discards a read in flight
    read = 1'b1;
    address = 8'hF0;
    reset = 1'b1;
    tick();
    read = 1'b0;
    chk("rst2_valid", 32'(data_valid), 32'h0);
    chk("rst2_data", 32'(data_out), 32'h00);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
